// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and types for the FIR tap accumulator
package fir_pkg;

    localparam int FIR_DATA_WIDTH = 16;
    localparam int FIR_ACC_WIDTH  = 20;
    localparam int FIR_NUM_TAPS   = 8;

    // ACCUM: taking tap terms; HOLD: presenting a completed sample
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - signed saturating add of a tap term into an accumulator
//
// Ports:
//   acc  - signed accumulator value (ACC_WIDTH)
//   term - signed term to add (DATA_WIDTH), sign-extended before the add
//   sum  - result clamped to the signed ACC_WIDTH range
//   ovf  - high when the clamp was applied
module sat_add #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 20
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [DATA_WIDTH-1:0] term,
    output logic [ACC_WIDTH-1:0]  sum,
    output logic                  ovf
);

    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH:0] acc_ext;
    logic [ACC_WIDTH:0] term_ext;
    logic [ACC_WIDTH:0] sum_wide;

    // One guard bit is enough: the add of two ACC_WIDTH-range values cannot
    // leave the ACC_WIDTH+1 range, so the top two bits disagree exactly
    // when the true result is outside the ACC_WIDTH range.
    assign acc_ext  = {acc[ACC_WIDTH-1], acc};
    assign term_ext = {{(ACC_WIDTH+1-DATA_WIDTH){term[DATA_WIDTH-1]}}, term};
    assign sum_wide = acc_ext + term_ext;

    always_comb begin
        ovf = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
        sum = sum_wide[ACC_WIDTH-1:0];
        if (ovf) begin
            // The guard bit carries the true sign of the result
            sum = sum_wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/fir_tap_accumulator.sv
// rtl/fir_tap_accumulator.sv - sums NUM_TAPS signed tap terms into one saturated sample
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   clr                 - synchronous frame abort (ignored while a sample is held)
//   in_valid/in_ready   - tap term handshake, in_data is the signed term
//   out_valid/out_ready - completed sample handshake
//   out_data            - signed saturated sum of the frame
//   out_ovf             - saturation occurred at some step of the frame
module fir_tap_accumulator
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int ACC_WIDTH  = FIR_ACC_WIDTH,
    parameter int NUM_TAPS   = FIR_NUM_TAPS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_ovf
);

    localparam int CNT_W = $clog2(NUM_TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

    acc_state_t           state;
    acc_state_t           state_next;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     tap_cnt;
    logic                 ovf_sticky;
    logic [ACC_WIDTH-1:0] step_sum;
    logic                 step_ovf;
    logic                 accept;
    logic                 last_tap;

    sat_add #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .acc (acc),
        .term(in_data),
        .sum (step_sum),
        .ovf (step_ovf)
    );

    // clr in ACCUM wins over a coincident term, which is simply dropped
    assign accept   = in_valid && in_ready && !clr;
    assign last_tap = (tap_cnt == LAST_TAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && last_tap) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            tap_cnt    <= '0;
            ovf_sticky <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (clr) begin
                        acc        <= '0;
                        tap_cnt    <= '0;
                        ovf_sticky <= 1'b0;
                    end else if (accept) begin
                        acc        <= step_sum;
                        ovf_sticky <= ovf_sticky | step_ovf;
                        if (last_tap) begin
                            // tap_cnt parks at the last index until handoff
                            out_data <= step_sum;
                            out_ovf  <= ovf_sticky | step_ovf;
                        end else begin
                            tap_cnt <= tap_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Outputs are left untouched so they stay stable under
                    // back-pressure and keep their value after handoff.
                    if (out_ready) begin
                        acc        <= '0;
                        tap_cnt    <= '0;
                        ovf_sticky <= 1'b0;
                    end
                end
                default: begin
                    acc        <= '0;
                    tap_cnt    <= '0;
                    ovf_sticky <= 1'b0;
                end
            endcase
        end
    end

endmodule
